// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, instruction bundle, issue FSM states and ALU function codes.
package pipe_pkg;
  localparam int REG_W = 4;
  localparam int FUNC_W = 4;
  localparam int ADDR_W = 8;
  localparam int INSTR_W = 3 * REG_W + FUNC_W + ADDR_W;
  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [FUNC_W-1:0] func;
    logic [ADDR_W-1:0] addr;
  } instr_t;
  typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_t;
  localparam logic [FUNC_W-1:0] F_ADD = 4'd0;
  localparam logic [FUNC_W-1:0] F_SUB = 4'd1;
  localparam logic [FUNC_W-1:0] F_MUL = 4'd2;
  localparam logic [FUNC_W-1:0] F_AND = 4'd3;
  localparam logic [FUNC_W-1:0] F_OR = 4'd4;
  localparam logic [FUNC_W-1:0] F_XOR = 4'd5;
endpackage

// File: rtl/issue_fifo.sv
// issue_fifo: synchronous FIFO with a combinational head read and count-derived full/empty.
module issue_fifo
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = INSTR_W
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic wr, rd;
  assign full = count == ($clog2(DEPTH) + 1)'(DEPTH);
  assign empty = count == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = mem[rptr];
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      count <= count + ($clog2(DEPTH) + 1)'(wr) - ($clog2(DEPTH) + 1)'(rd);
    end
  end
endmodule

// File: rtl/pipe_issue.sv
// pipe_issue: FIFO-buffered in-order issue with a shift-register scoreboard that
// bubbles the head until any in-flight destination it reads has been written back.
module pipe_issue
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [REG_W-1:0] in_rs1,
  input  logic [REG_W-1:0] in_rs2,
  input  logic [REG_W-1:0] in_rd,
  input  logic [FUNC_W-1:0] in_func,
  input  logic [ADDR_W-1:0] in_addr,
  output logic [REG_W-1:0] rs1,
  output logic [REG_W-1:0] rs2,
  output logic [REG_W-1:0] rd,
  output logic [FUNC_W-1:0] func,
  output logic [ADDR_W-1:0] addr,
  output logic issue_valid,
  output logic stall,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0] hazard_cnt
);
  instr_t head;
  state_t st;
  logic full, empty, hit, hz, go;
  logic [PIPE_LAT-1:0] sb_v;
  logic [REG_W-1:0] sb_rd [PIPE_LAT];
  assign in_ready = !full;
  assign stall = st == STALL;
  issue_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(in_valid && in_ready),
    .pop(go),
    .din({in_rs1, in_rs2, in_rd, in_func, in_addr}),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < PIPE_LAT; i++)
      hit = hit | (sb_v[i] && (sb_rd[i] == head.rs1 || sb_rd[i] == head.rs2));
  end
  assign hz = !empty && hit;
  assign go = !empty && !hit;
  always_ff @(posedge clk) begin
    sb_rd[0] <= head.rd;
    for (int i = 1; i < PIPE_LAT; i++) sb_rd[i] <= sb_rd[i-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_v <= '0;
      st <= IDLE;
      {rs1, rs2, rd, func, addr} <= '0;
      issue_valid <= 1'b0;
      hazard_cnt <= '0;
    end else begin
      sb_v[0] <= go;
      for (int i = 1; i < PIPE_LAT; i++) sb_v[i] <= sb_v[i-1];
      issue_valid <= go;
      if (go) {rs1, rs2, rd, func, addr} <= head;
      st <= hz ? STALL : go ? ISSUE : IDLE;
      hazard_cnt <= hazard_cnt + 8'(hz && hazard_cnt != 8'hff);
    end
  end
endmodule

// File: tb/tb_pipe_issue.sv
// tb_pipe_issue: directed scenarios plus random traffic against a queue/last-write-time model.
module tb_pipe_issue;
  import pipe_pkg::*;
  localparam int DEPTH = 4;
  localparam int LAT = 3;
  logic clk = 0, rst = 0, in_valid = 0, in_ready, issue_valid, stall;
  logic [3:0] in_rs1 = 0, in_rs2 = 0, in_rd = 0, in_func = 0, rs1, rs2, rd, func;
  logic [7:0] in_addr = 0, addr, hazard_cnt;
  logic [$clog2(DEPTH):0] count;
  int n_cmp = 0, n_err = 0, t = 0;
  instr_t q[$];
  int last[16];
  instr_t e_ops;
  logic e_iv, e_st;
  int e_hc;
  pipe_issue #(.DEPTH(DEPTH), .PIPE_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func), .in_addr(in_addr),
    .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
    .issue_valid(issue_valid), .stall(stall), .count(count), .hazard_cnt(hazard_cnt)
  );
  always #5 clk = ~clk;
  function automatic instr_t mk(int a, int b, int c, int d, int e);
    return '{rs1: 4'(a), rs2: 4'(b), rd: 4'(c), func: 4'(d), addr: 8'(e)};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, t);
    end
  endtask
  task automatic step(input logic v, input instr_t d, input logic r);
    logic ready, hz;
    instr_t h;
    in_valid = v;
    {in_rs1, in_rs2, in_rd, in_func, in_addr} = d;
    rst = r;
    @(posedge clk);
    t++;
    if (r) begin
      q.delete();
      foreach (last[i]) last[i] = -1000;
      e_ops = '0;
      e_iv = 0;
      e_st = 0;
      e_hc = 0;
    end else begin
      ready = q.size() < DEPTH;
      e_iv = 0;
      e_st = 0;
      if (q.size() > 0) begin
        h = q[0];
        hz = (t - last[h.rs1] <= LAT) || (t - last[h.rs2] <= LAT);
        if (hz) begin
          e_st = 1;
          if (e_hc < 255) e_hc++;
        end else begin
          e_ops = h;
          e_iv = 1;
          last[h.rd] = t;
          void'(q.pop_front());
        end
      end
      if (v && ready) q.push_back(d);
    end
    #1;
    check("issue_valid", 32'(issue_valid), 32'(e_iv));
    check("stall", 32'(stall), 32'(e_st));
    check("count", 32'(count), 32'(q.size()));
    check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    check("hazard_cnt", 32'(hazard_cnt), 32'(e_hc));
    check("operands", 32'({rs1, rs2, rd, func, addr}), 32'(e_ops));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0);
  endtask
  initial begin
    step(1, mk(1, 2, 3, 4, 5), 1);
    step(1, mk(1, 2, 3, 4, 5), 1);
    check("reset_ops_zero", 32'({rs1, rs2, rd, func, addr}), 32'd0);
    check("reset_ready", 32'(in_ready), 32'd1);
    step(1, mk(3, 5, 10, 0, 125), 0);
    step(1, mk(3, 8, 12, 2, 126), 0);
    step(1, mk(7, 3, 13, 11, 127), 0);
    idle(5);
    check("indep_no_stall", 32'(hazard_cnt), 32'd0);
    step(0, '0, 1);
    step(1, mk(3, 5, 10, 0, 125), 0);
    step(1, mk(10, 5, 14, 1, 128), 0);
    idle(7);
    check("raw_hazard_cnt", 32'(hazard_cnt), 32'd3);
    step(0, '0, 1);
    step(1, mk(1, 2, 12, 0, 1), 0);
    step(1, mk(3, 4, 5, 0, 2), 0);
    step(1, mk(6, 12, 7, 0, 3), 0);
    idle(6);
    check("partial_hazard_cnt", 32'(hazard_cnt), 32'd2);
    step(0, '0, 1);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 6; i++) begin
        step(1, mk(9, 9, 9, i, 16 * k + i), 0);
        if (i == 4) begin
          check("full_count", 32'(count), 32'd4);
          check("full_ready", 32'(in_ready), 32'd0);
        end
      end
      idle(24);
    end
    step(0, '0, 1);
    for (int i = 0; i < 4; i++) step(1, mk(9, 9, 9, 1, 40 + i), 0);
    check("pre_reset_stall", 32'(stall), 32'd1);
    check("pre_reset_count", 32'(count), 32'd3);
    step(0, '0, 1);
    check("mid_reset_count", 32'(count), 32'd0);
    check("mid_reset_stall", 32'(stall), 32'd0);
    idle(3);
    step(1, mk(9, 9, 9, 2, 77), 0);
    step(0, '0, 0);
    check("post_reset_issue", 32'(issue_valid), 32'd1);
    idle(4);
    for (int i = 0; i < 3000; i++) begin
      step($urandom % 4 != 0,
           mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 15), $urandom_range(0, 255)),
           $urandom % 200 == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_issue.md
Name: pipe_issue

Overview:
- Instruction issue unit for the 4-stage register/ALU/memory pipeline. It is the initiator that drives the pipeline's rs1/rs2/rd/func/addr operand ports.
- Buffers instructions from a producer in a small FIFO and presents at most one per cycle to the pipeline.
- Detects read-after-write hazards against in-flight destinations and inserts bubbles until the producing instruction has written the register bank.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- PIPE_LAT, 3, cycles after issue before the issued rd is readable (scoreboard length)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  producer has an instruction
- in_ready  out  1  FIFO can accept; equals !full
- in_rs1  in  4  source register 1
- in_rs2  in  4  source register 2
- in_rd  in  4  destination register
- in_func  in  4  ALU function code
- in_addr  in  8  memory result address
- rs1, rs2, rd, func  out  4 each  operands to pipeline (registered)
- addr  out  8  result address to pipeline (registered)
- issue_valid  out  1  high for exactly the cycles in which operand outputs carry a new instruction
- stall  out  1  head instruction blocked by a hazard this cycle
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- hazard_cnt  out  8  number of stall cycles, saturating at 255

Behaviour:
- Reset: all outputs 0 except in_ready=1. FIFO is emptied, scoreboard valid bits are cleared, FSM goes to IDLE. Reset mid-operation discards queued and in-flight tracking with no partial issue.
- Push: occurs when in_valid && in_ready at the rising edge. A push while full cannot happen, because in_ready=0. When full, a same-cycle pop does not raise in_ready; this is deliberately conservative.
- Scoreboard:
  - PIPE_LAT slots, each holding {valid, rd}. sb[0] is the slot issued in the previous cycle.
  - Every cycle the scoreboard shifts by one. The new slot is {issue, rd_issued}; on a bubble it is {0, x}.
- Hazard: the head entry's rs1 or rs2 equals sb[i].rd for any i with sb[i].valid. There is no forwarding. rs1==rs2 is handled naturally.
- Pop/issue: when FIFO is non-empty and there is no hazard, the head is registered onto rs1..addr, issue_valid=1 for one cycle, and the head pops.
- Outputs when not issuing: operand outputs hold their previous values and issue_valid=0.
- Latency: an instruction pushed at edge N is issuable at the earliest at edge N+1. There is no empty-FIFO bypass.
- FSM:
  - IDLE (empty): to ISSUE on a non-empty FIFO with no hazard; to STALL on a non-empty FIFO with a hazard.
  - ISSUE: stays in ISSUE while the next head is clear; goes to STALL on a hazard; goes to IDLE when the FIFO drains.
  - STALL: stall=1, hazard_cnt increments (saturating). Goes to ISSUE when the hazard clears; the maximum stall is PIPE_LAT cycles.
- A push and a pop in the same cycle leave count unchanged.
- Pointer arithmetic: read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. full and empty are derived from count.
- Back-to-back independent instructions issue one per cycle. Throughput is limited only by hazards.

Decomposition:
- Shared package pipe_pkg:
  - REG_W=4, FUNC_W=4, ADDR_W=8
  - INSTR_W=20 packed bundle {rs1, rs2, rd, func, addr}
  - FSM state encoding IDLE/ISSUE/STALL
  - func code constants shared with the pipeline (ADD=0, SUB=1, MUL=2, ...)
- Sub-module issue_fifo: parameterised DEPTH×INSTR_W synchronous FIFO with push/pop/count/full/empty. The scoreboard and FSM live in pipe_issue.

Test Plan:
- Reset: assert rst for 2 cycles while in_valid=1 → count=0, issue_valid=0, in_ready=1, all operand outputs 0. Push during reset is ignored.
- Independent stream: push {3,5,10,0,125}, {3,8,12,2,126}, {7,3,13,11,127} on consecutive cycles → issue_valid high for 3 consecutive cycles in order, stall never asserted, hazard_cnt=0.
- RAW hazard: push {3,5,10,0,125} then {10,5,14,1,128} → second instruction issues exactly 4 cycles after the first. stall=1 for the 3 cycles in between and hazard_cnt=3.
- Partial hazard: rd=12 issued, then one independent instruction, then an instruction with rs2=12 → 2 bubble cycles, hazard_cnt increments by 2.
- Full FIFO: hold the head in a hazard and push until in_ready=0 → count=4, a 5th push is not accepted. After drain, order is preserved and pointers wrap correctly across 2 full fill/drain cycles.
- Reset mid-stall: assert rst while stall=1 with count=3 → the next cycle shows count=0, stall=0, and no further issue_valid. A fresh independent push issues after 1 cycle with no residual hazard.
